// File: rtl/divider_if.sv
// Pipeline-side handshake bundle for the iterative divider: operands, request,
// result and stall, plus the divider's FSM state for observation.
interface divider_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             start;
  logic [2:0]       div_funct3;
  logic [WIDTH-1:0] div_fout;
  logic             div_stall;
  logic [1:0]       div_state;

  // start is held with stable operands while div_stall is high; the request
  // completes in the cycle where start is high and div_stall is low.
  modport master (output a, b, start, div_funct3, input div_fout, div_stall, div_state);
  modport slave  (input a, b, start, div_funct3, output div_fout, div_stall, div_state);
endinterface

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Normal operations take 33 cycles; divide-by-zero and signed overflow take 1.
module divider #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   divider_if.slave   bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state, next_state;
   logic [4:0]       cnt;
   logic [WIDTH:0]   rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] div_r;
   logic             sign_q, sign_r, sel_rem;
   logic [WIDTH-1:0] fout_r;

   // Unsupported funct3 (bit 2 clear) falls through to the unsigned datapath.
   logic             signed_op;
   logic [WIDTH-1:0] a_abs, b_abs;
   logic             div_zero, ovf, special;

   assign signed_op = bus.div_funct3[2] & ~bus.div_funct3[0];
   assign a_abs     = (signed_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign b_abs     = (signed_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
   assign div_zero  = (bus.b == '0);
   assign ovf       = signed_op & (bus.a == MIN_NEG) & (bus.b == '1);
   assign special   = div_zero | ovf;

   logic [WIDTH:0]   r_sh, t, r_nx;
   logic [WIDTH-1:0] q_nx, quo_fix, rem_fix;

   assign r_sh    = {rem_r[WIDTH-1:0], quo_r[WIDTH-1]};
   assign t       = r_sh - {1'b0, div_r};
   assign r_nx    = t[WIDTH] ? r_sh : t;
   assign q_nx    = {quo_r[WIDTH-2:0], ~t[WIDTH]};
   assign quo_fix = sign_q ? -q_nx : q_nx;
   assign rem_fix = sign_r ? -r_nx[WIDTH-1:0] : r_nx[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = special ? DONE : CALC;
         CALC:    if (cnt == 5'd0) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= 5'd0;
         rem_r   <= '0;
         quo_r   <= '0;
         div_r   <= '0;
         sign_q  <= 1'b0;
         sign_r  <= 1'b0;
         sel_rem <= 1'b0;
         fout_r  <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               sel_rem <= bus.div_funct3[1];
               sign_q  <= signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               sign_r  <= signed_op & bus.a[WIDTH-1];
               div_r   <= b_abs;
               if (div_zero)
                  fout_r <= bus.div_funct3[1] ? bus.a : '1;
               else if (ovf)
                  fout_r <= bus.div_funct3[1] ? '0 : MIN_NEG;
               else begin
                  rem_r <= '0;
                  quo_r <= a_abs;
                  cnt   <= 5'd31;
               end
            end
            CALC: begin
               rem_r <= r_nx;
               quo_r <= q_nx;
               cnt   <= cnt - 5'd1;
               if (cnt == 5'd0) fout_r <= sel_rem ? rem_fix : quo_fix;
            end
            default: ;
         endcase
      end
   end

   // Stall is forced low in reset so a held start cannot leak through.
   assign bus.div_stall = rst & (((state == IDLE) & bus.start) | (state == CALC));
   assign bus.div_fout  = fout_r;
   assign bus.div_state = state;

endmodule
